// File: rtl/jtdsp16_do_cache.sv
// DSP16 do/redo loop sequencer: captures the loop body while it executes from ROM,
// then replays it from a small instruction cache with the program counter held.
module jtdsp16_do_cache #(
    parameter int CW = 15,
    parameter int KW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          do_start,
    input  logic          redo_start,
    input  logic [3:0]    ni,
    input  logic [KW-1:0] k,
    input  logic          ins_adv,
    input  logic [15:0]   rom_dout,
    output logic [15:0]   cache_dout,
    output logic          cache_sel,
    output logic          pc_hold,
    output logic          busy,
    output logic          done,
    output logic [KW-1:0] cnt_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REPLAY = 2'd2
    } state_t;

    localparam logic [KW-1:0] CNT_ONE = KW'(1);
    localparam logic [4:0]    NI_MAX  = 5'(CW);

    state_t        state;
    logic [3:0]    wr_ptr;
    logic [3:0]    rd_ptr;
    logic [3:0]    ni_q;
    logic [KW-1:0] cnt;
    logic          cache_valid;
    logic          done_q;
    logic [15:0]   cache [0:CW-1];

    logic          ni_ok;
    logic [KW-1:0] k_eff;
    logic [3:0]    last_ptr;
    logic          fill_wr;

    // A zero repeat count still runs the body once.
    always_comb begin
        ni_ok    = (ni != 4'd0) && ({1'b0, ni} <= NI_MAX);
        k_eff    = (k == '0) ? CNT_ONE : k;
        last_ptr = ni_q - 4'd1;
        fill_wr  = cen && !rst && (state == FILL) && ins_adv;
    end

    // NOTE: the cache array has no reset; only cache_valid says whether it holds a body.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            cache[wr_ptr] <= rom_dout;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= 4'd0;
            rd_ptr      <= 4'd0;
            ni_q        <= 4'd0;
            cnt         <= '0;
            cache_valid <= 1'b0;
            done_q      <= 1'b0;
        end else if (cen) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_start) begin
                        if (ni_ok) begin
                            state       <= FILL;
                            ni_q        <= ni;
                            cnt         <= k_eff;
                            wr_ptr      <= 4'd0;
                            cache_valid <= 1'b0;
                        end
                    end else if (redo_start && cache_valid) begin
                        state  <= REPLAY;
                        cnt    <= k_eff;
                        rd_ptr <= 4'd0;
                    end
                end

                FILL: begin
                    if (ins_adv) begin
                        wr_ptr <= wr_ptr + 4'd1;
                        if (wr_ptr == last_ptr) begin
                            cache_valid <= 1'b1;
                            if (cnt == CNT_ONE) begin
                                state  <= IDLE;
                                done_q <= 1'b1;
                            end else begin
                                cnt    <= cnt - CNT_ONE;
                                rd_ptr <= 4'd0;
                                state  <= REPLAY;
                            end
                        end
                    end
                end

                REPLAY: begin
                    if (ins_adv) begin
                        if (rd_ptr == last_ptr) begin
                            rd_ptr <= 4'd0;
                            if (cnt == CNT_ONE) begin
                                state  <= IDLE;
                                done_q <= 1'b1;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + 4'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode directly from registered state so they are valid right after each edge.
    always_comb begin
        cache_sel  = (state == REPLAY);
        pc_hold    = (state == REPLAY);
        busy       = (state != IDLE);
        done       = done_q;
        cnt_dout   = busy ? cnt : '0;
        cache_dout = (state == REPLAY) ? cache[rd_ptr] : 16'h0000;
    end

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Directed bench for jtdsp16_do_cache: fill, replay, redo, stalls, blocked commands, reset.
module tb_jtdsp16_do_cache;

    localparam int KW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen;
    logic          do_start;
    logic          redo_start;
    logic [3:0]    ni;
    logic [KW-1:0] k;
    logic          ins_adv;
    logic [15:0]   rom_dout;
    logic [15:0]   cache_dout;
    logic          cache_sel;
    logic          pc_hold;
    logic          busy;
    logic          done;
    logic [KW-1:0] cnt_dout;

    int checks = 0;
    int errors = 0;

    logic [15:0] w3 [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [15:0] w2 [2] = '{16'hAAAA, 16'hBBBB};

    jtdsp16_do_cache dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .do_start   (do_start),
        .redo_start (redo_start),
        .ni         (ni),
        .k          (k),
        .ins_adv    (ins_adv),
        .rom_dout   (rom_dout),
        .cache_dout (cache_dout),
        .cache_sel  (cache_sel),
        .pc_hold    (pc_hold),
        .busy       (busy),
        .done       (done),
        .cnt_dout   (cnt_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},  32'(busy),       32'd0);
        check({tag, ".sel"},   32'(cache_sel),  32'd0);
        check({tag, ".hold"},  32'(pc_hold),    32'd0);
        check({tag, ".cnt"},   32'(cnt_dout),   32'd0);
        check({tag, ".dout"},  32'(cache_dout), 32'd0);
    endtask

    task automatic issue_redo(input logic [KW-1:0] kk);
        redo_start = 1'b1;
        k          = kk;
        step();
        redo_start = 1'b0;
    endtask

    initial begin
        // NOTE: stimulus uses blocking assignments; the #1 offset keeps it clear of the edge.
        rst = 1'b1; cen = 1'b1; do_start = 1'b0; redo_start = 1'b0;
        ni = 4'd0; k = '0; ins_adv = 1'b0; rom_dout = 16'h0000;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset.done", 32'(done), 32'd0);

        // redo with an empty cache and do with ni=0 are both ignored
        issue_redo(7'd3);
        check("redo_empty.busy", 32'(busy), 32'd0);
        do_start = 1'b1; ni = 4'd0; k = 7'd2;
        step();
        do_start = 1'b0;
        check("do_ni0.busy", 32'(busy), 32'd0);

        // do ni=3 k=4: three fill cycles then three replay passes
        do_start = 1'b1; ni = 4'd3; k = 7'd4;
        step();
        do_start = 1'b0;
        ins_adv  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rom_dout = w3[i];
            check("fill.sel",  32'(cache_sel), 32'd0);
            check("fill.hold", 32'(pc_hold),   32'd0);
            check("fill.busy", 32'(busy),      32'd1);
            check("fill.cnt",  32'(cnt_dout),  32'd4);
            step();
        end
        rom_dout = 16'hDEAD;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++) begin
                check("rep.sel",  32'(cache_sel),  32'd1);
                check("rep.hold", 32'(pc_hold),    32'd1);
                check("rep.dout", 32'(cache_dout), 32'(w3[i]));
                check("rep.cnt",  32'(cnt_dout),   32'(3 - p));
                check("rep.done", 32'(done),       32'd0);
                step();
            end
        end
        ins_adv = 1'b0;
        check("main.done", 32'(done), 32'd1);
        check_idle("main.end");
        step();
        check("main.done_clr", 32'(done), 32'd0);

        // redo k=2 replays the cached body twice; a do during replay is ignored
        issue_redo(7'd2);
        ins_adv = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                do_start = (p == 0 && i == 1);
                ni = 4'd1; k = 7'd5;
                check("redo.hold", 32'(pc_hold),    32'd1);
                check("redo.dout", 32'(cache_dout), 32'(w3[i]));
                check("redo.cnt",  32'(cnt_dout),   32'(2 - p));
                step();
            end
        end
        do_start = 1'b0; ins_adv = 1'b0;
        check("redo.done", 32'(done), 32'd1);
        check("redo.busy", 32'(busy), 32'd0);
        step();

        // ins_adv stall mid-pass freezes pointer and count
        issue_redo(7'd2);
        ins_adv = 1'b1;
        step();
        ins_adv = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("stall.dout", 32'(cache_dout), 32'h2222);
            check("stall.cnt",  32'(cnt_dout),   32'd2);
            step();
        end
        ins_adv = 1'b1;
        for (int j = 1; j < 6; j++) begin
            check("stall.resume", 32'(cache_dout), 32'(w3[j % 3]));
            check("stall.rcnt",   32'(cnt_dout),   32'(j < 3 ? 2 : 1));
            step();
        end
        ins_adv = 1'b0;
        check("stall.done", 32'(done), 32'd1);
        step();

        // cen toggling: nothing advances while cen is low, done holds
        issue_redo(7'd1);
        ins_adv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cen = 1'b0;
            check("cen.dout_lo", 32'(cache_dout), 32'(w3[i]));
            step();
            cen = 1'b1;
            check("cen.dout_hi", 32'(cache_dout), 32'(w3[i]));
            step();
        end
        ins_adv = 1'b0;
        cen = 1'b0;
        check("cen.done", 32'(done), 32'd1);
        step();
        check("cen.done_hold", 32'(done), 32'd1);
        cen = 1'b1;
        step();
        check("cen.done_clr", 32'(done), 32'd0);

        // do ni=2 with k=1 and k=0: fill only, no replay
        for (int t = 0; t < 2; t++) begin
            do_start = 1'b1; ni = 4'd2; k = (t == 0) ? 7'd1 : 7'd0;
            step();
            do_start = 1'b0;
            ins_adv  = 1'b1;
            for (int i = 0; i < 2; i++) begin
                rom_dout = w2[i];
                check("short.sel", 32'(cache_sel), 32'd0);
                check("short.cnt", 32'(cnt_dout),  32'd1);
                step();
            end
            ins_adv = 1'b0;
            check("short.done", 32'(done), 32'd1);
            check("short.busy", 32'(busy), 32'd0);
            step();
        end

        // cache_valid left set: redo replays the new body
        issue_redo(7'd3);
        ins_adv = 1'b1;
        check("rst.dout0", 32'(cache_dout), 32'hAAAA);
        check("rst.busy",  32'(busy),       32'd1);
        step();
        check("rst.dout1", 32'(cache_dout), 32'hBBBB);
        rst = 1'b1;
        step();
        rst = 1'b0; ins_adv = 1'b0;
        check_idle("rst.mid");
        check("rst.done", 32'(done), 32'd0);
        issue_redo(7'd3);
        check("rst.redo_blocked", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
